// File: rtl/ddr4_refresh_sched.sv
// DDR4 refresh scheduler: tracks the tREFI interval, postpones refreshes
// while the command bus is busy, and issues PREA/REF with tRP/tRFC spacing.
module ddr4_refresh_sched #(
    parameter int TREFI_CYC    = 1950,
    parameter int TRP_CYC      = 4,
    parameter int TRFC_CYC     = 88,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       dfi_clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       ref_gnt,
    output logic       ref_req,
    output logic       ref_urgent,
    output logic       busy,
    output logic       cmd_valid,
    output logic [4:0] cmd,
    output logic       cmd_a10,
    output logic [3:0] pend_cnt,
    output logic       ovf_err
);

    localparam int IW   = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
    localparam int WMAX = (TRFC_CYC > TRP_CYC) ? TRFC_CYC : TRP_CYC;
    localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

    localparam logic [4:0] CMD_NOP  = 5'b0_1111;
    localparam logic [4:0] CMD_PREA = 5'b0_1010;
    localparam logic [4:0] CMD_REF  = 5'b0_1001;

    typedef enum logic [2:0] {
        IDLE,
        PREA,
        TRP_WAIT,
        REF,
        TRFC_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ivl_q, ivl_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [3:0]    pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          ref_req_q, ref_req_d;
    logic          urgent_q, urgent_d;
    logic          busy_q, busy_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [4:0]    cmd_q, cmd_d;
    logic          a10_q, a10_d;
    logic          tick;
    logic          dec;

    always_comb begin
        tick  = init_done && (ivl_q == IW'(TREFI_CYC - 1));
        ivl_d = (!init_done || tick) ? '0 : ivl_q + 1'b1;
        dec   = (state_q == REF) && (pend_q != 4'd0);

        // Tick and decrement together cancel; neither counts as overflow.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (!init_done) begin
            pend_d = 4'd0;
        end else if (tick && !dec) begin
            if (pend_q == 4'(MAX_POSTPONE)) ovf_d = 1'b1;
            else                            pend_d = pend_q + 4'd1;
        end else if (!tick && dec) begin
            pend_d = pend_q - 4'd1;
        end

        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (ref_req_q && ref_gnt) state_d = PREA;
            end
            PREA: begin
                state_d = TRP_WAIT;
                wait_d  = WW'(TRP_CYC - 1);
            end
            TRP_WAIT: begin
                if (wait_q == '0) state_d = REF;
                else              wait_d  = wait_q - 1'b1;
            end
            REF: begin
                state_d = TRFC_WAIT;
                wait_d  = WW'(TRFC_CYC - 1);
            end
            TRFC_WAIT: begin
                if (wait_q == '0) state_d = IDLE;
                else              wait_d  = wait_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ref_req_d   = (state_d == IDLE) && (pend_d != 4'd0) && init_done;
        urgent_d    = (pend_d == 4'(MAX_POSTPONE));
        busy_d      = (state_d != IDLE);
        cmd_valid_d = (state_d == PREA) || (state_d == REF);
        cmd_d       = CMD_NOP;
        a10_d       = 1'b0;
        if (state_d == PREA) begin
            cmd_d = CMD_PREA;
            a10_d = 1'b1;
        end else if (state_d == REF) begin
            cmd_d = CMD_REF;
        end
    end

    always_ff @(posedge dfi_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ivl_q       <= '0;
            wait_q      <= '0;
            pend_q      <= 4'd0;
            ovf_q       <= 1'b0;
            ref_req_q   <= 1'b0;
            urgent_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            a10_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ivl_q       <= ivl_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            ref_req_q   <= ref_req_d;
            urgent_q    <= urgent_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            a10_q       <= a10_d;
        end
    end

    assign ref_req    = ref_req_q;
    assign ref_urgent = urgent_q;
    assign busy       = busy_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd        = cmd_q;
    assign cmd_a10    = a10_q;
    assign pend_cnt   = pend_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_ddr4_refresh_sched.sv
// Directed bench for ddr4_refresh_sched with short timing parameters.
module tb_ddr4_refresh_sched;

    logic       dfi_clk = 1'b0;
    logic       reset;
    logic       init_done;
    logic       ref_gnt;
    logic       ref_req;
    logic       ref_urgent;
    logic       busy;
    logic       cmd_valid;
    logic [4:0] cmd;
    logic       cmd_a10;
    logic [3:0] pend_cnt;
    logic       ovf_err;

    int n_chk = 0;
    int n_fail = 0;

    ddr4_refresh_sched #(
        .TREFI_CYC   (20),
        .TRP_CYC     (3),
        .TRFC_CYC    (10),
        .MAX_POSTPONE(8)
    ) dut (
        .dfi_clk   (dfi_clk),
        .reset     (reset),
        .init_done (init_done),
        .ref_gnt   (ref_gnt),
        .ref_req   (ref_req),
        .ref_urgent(ref_urgent),
        .busy      (busy),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_a10   (cmd_a10),
        .pend_cnt  (pend_cnt),
        .ovf_err   (ovf_err)
    );

    always #5 dfi_clk = ~dfi_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge dfi_clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        init_done = 1'b0;
        ref_gnt   = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        init_done = 1'b0;
        ref_gnt   = 1'b0;
        #2;
        chk("rst_cmd",   {27'd0, cmd}, 32'h0F);
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_pend",  {28'd0, pend_cnt}, 0);
        chk("rst_req",   {31'd0, ref_req}, 0);
        chk("rst_valid", {31'd0, cmd_valid}, 0);
        chk("rst_ovf",   {31'd0, ovf_err}, 0);
        chk("rst_urg",   {31'd0, ref_urgent}, 0);
        chk("rst_a10",   {31'd0, cmd_a10}, 0);

        // Idle until init_done, grant ignored.
        do_reset();
        ref_gnt = 1'b1;
        step(30);
        chk("noinit_req",  {31'd0, ref_req}, 0);
        chk("noinit_pend", {28'd0, pend_cnt}, 0);
        chk("noinit_busy", {31'd0, busy}, 0);

        // Basic refresh with grant held.
        init_done = 1'b1;
        step(19);
        chk("b_req19", {31'd0, ref_req}, 0);
        step(1);
        chk("b_req20",  {31'd0, ref_req}, 1);
        chk("b_pend20", {28'd0, pend_cnt}, 1);
        step(1);
        chk("b_prea",     {27'd0, cmd}, 32'h0A);
        chk("b_prea_v",   {31'd0, cmd_valid}, 1);
        chk("b_prea_a10", {31'd0, cmd_a10}, 1);
        chk("b_prea_bsy", {31'd0, busy}, 1);
        chk("b_prea_req", {31'd0, ref_req}, 0);
        step(3);
        chk("b_trp_nop", {27'd0, cmd}, 32'h0F);
        chk("b_trp_v",   {31'd0, cmd_valid}, 0);
        step(1);
        chk("b_ref",      {27'd0, cmd}, 32'h09);
        chk("b_ref_a10",  {31'd0, cmd_a10}, 0);
        chk("b_ref_pend", {28'd0, pend_cnt}, 1);
        step(1);
        chk("b_pend0", {28'd0, pend_cnt}, 0);
        chk("b_nop",   {27'd0, cmd}, 32'h0F);
        step(9);
        chk("b_busy10", {31'd0, busy}, 1);
        step(1);
        chk("b_busy11", {31'd0, busy}, 0);
        chk("b_req_end", {31'd0, ref_req}, 0);

        // Postpone until saturation and overflow.
        do_reset();
        init_done = 1'b1;
        step(159);
        chk("s_pend159", {28'd0, pend_cnt}, 7);
        chk("s_urg159",  {31'd0, ref_urgent}, 0);
        step(1);
        chk("s_pend160", {28'd0, pend_cnt}, 8);
        chk("s_urg160",  {31'd0, ref_urgent}, 1);
        step(19);
        chk("s_ovf179", {31'd0, ovf_err}, 0);
        step(1);
        chk("s_ovf180",  {31'd0, ovf_err}, 1);
        chk("s_pend180", {28'd0, pend_cnt}, 8);
        step(20);
        chk("s_ovf_sticky", {31'd0, ovf_err}, 1);

        // Tick coincident with REF at pend_cnt=3.
        do_reset();
        init_done = 1'b1;
        step(60);
        chk("c_pend60", {28'd0, pend_cnt}, 3);
        step(14);
        ref_gnt = 1'b1;
        step(1);
        ref_gnt = 1'b0;
        chk("c_prea", {27'd0, cmd}, 32'h0A);
        step(4);
        chk("c_ref",  {27'd0, cmd}, 32'h09);
        chk("c_pref", {28'd0, pend_cnt}, 3);
        step(1);
        chk("c_pend80", {28'd0, pend_cnt}, 3);
        chk("c_ovf80",  {31'd0, ovf_err}, 0);

        // Grant pulse during tRFC wait changes nothing.
        step(3);
        ref_gnt = 1'b1;
        step(1);
        ref_gnt = 1'b0;
        chk("g_cmd",   {27'd0, cmd}, 32'h0F);
        chk("g_valid", {31'd0, cmd_valid}, 0);
        chk("g_busy",  {31'd0, busy}, 1);
        step(5);
        chk("g_busy89", {31'd0, busy}, 1);
        step(1);
        chk("g_busy90", {31'd0, busy}, 0);
        chk("g_req90",  {31'd0, ref_req}, 1);
        chk("g_cmd90",  {27'd0, cmd}, 32'h0F);

        // Reset in tRP wait aborts at once.
        ref_gnt = 1'b1;
        step(1);
        ref_gnt = 1'b0;
        chk("r_prea", {27'd0, cmd}, 32'h0A);
        step(1);
        reset = 1'b1;
        #1;
        chk("r_cmd",  {27'd0, cmd}, 32'h0F);
        chk("r_busy", {31'd0, busy}, 0);
        chk("r_pend", {28'd0, pend_cnt}, 0);
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("r_noref", {31'd0, cmd_valid}, 0);
        end

        // init_done drop during tRP wait.
        do_reset();
        init_done = 1'b1;
        step(40);
        chk("d_pend40", {28'd0, pend_cnt}, 2);
        ref_gnt = 1'b1;
        step(1);
        ref_gnt = 1'b0;
        chk("d_prea", {27'd0, cmd}, 32'h0A);
        step(1);
        init_done = 1'b0;
        step(1);
        chk("d_pend43", {28'd0, pend_cnt}, 0);
        chk("d_busy43", {31'd0, busy}, 1);
        step(2);
        chk("d_ref",  {27'd0, cmd}, 32'h09);
        step(1);
        chk("d_nounder", {28'd0, pend_cnt}, 0);
        step(10);
        chk("d_busy56", {31'd0, busy}, 0);
        chk("d_req56",  {31'd0, ref_req}, 0);
        step(30);
        chk("d_req86",  {31'd0, ref_req}, 0);
        chk("d_pend86", {28'd0, pend_cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
